// File: rtl/soc_pio_pkg.sv
// -----------------------------------------------------------------------------
// soc_pio_pkg
//   Definitions shared by the parallel I/O slaves on the system interconnect
//   (hex-digit output PIOs and the key/switch input PIO).
//
//   Contents:
//     pio_addr_e        - register offsets within a PIO slave (word addresses)
//     EDGE_*            - edge-detect selections for input PIOs
//     PIO_BUS_W         - Avalon-MM data width of every PIO slave
//     pio_write_strobe  - decodes an Avalon-MM write cycle
// -----------------------------------------------------------------------------
package soc_pio_pkg;

    // Avalon-MM data bus width used by all PIO slaves.
    localparam int PIO_BUS_W = 32;

    // Register offsets. Offset 1 is the direction register on bidirectional
    // PIOs; input-only PIOs treat it as reserved.
    typedef enum logic [1:0] {
        PIO_ADDR_DATA    = 2'd0,
        PIO_ADDR_DIR     = 2'd1,
        PIO_ADDR_IRQMASK = 2'd2,
        PIO_ADDR_EDGECAP = 2'd3
    } pio_addr_e;

    // Edge-detect selections.
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // A write cycle is a selected slave with the active-low strobe asserted.
    function automatic logic pio_write_strobe(input logic chipselect,
                                              input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage : soc_pio_pkg

// File: rtl/soc_input_debounce.sv
// -----------------------------------------------------------------------------
// soc_input_debounce
//   One input bit: two-flop synchroniser followed by a stability counter.
//   The debounced output only follows the synchronised input after it has
//   differed from the current output for DEBOUNCE_CYCLES consecutive clocks.
//   DEBOUNCE_CYCLES = 0 removes the counter; the output then follows the
//   synchroniser one clock later.
//
//   Parameters:
//     DEBOUNCE_CYCLES - clocks of stability required before acceptance
//     IDLE_LEVEL      - reset value of the synchroniser and the output
//
//   Ports:
//     clk     in   system clock
//     reset_n in   asynchronous active-low reset
//     in_bit  in   asynchronous external input
//     deb     out  synchronised, debounced level
// -----------------------------------------------------------------------------
module soc_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic deb
);

    // Counter wide enough to hold DEBOUNCE_CYCLES; never narrower than 1 bit.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic sync1;
    logic sync2;

    // ---- stage: metastability synchroniser (in_bit -> sync1 -> sync2) ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= in_bit;
            sync2 <= sync1;
        end
    end

    // ---- stage: debounce (sync2 -> deb) ----
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    deb <= IDLE_LEVEL;
                end else begin
                    deb <= sync2;
                end
            end
        end else begin : g_count
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt;

            // The counter measures how long sync2 has disagreed with deb.
            // Any agreement (a glitch back) restarts the measurement; the
            // edge that completes the count also accepts the new level.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt <= '0;
                    deb <= IDLE_LEVEL;
                end else if (sync2 == deb) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    deb <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule : soc_input_debounce

// File: rtl/soc_key_input_pio.sv
// -----------------------------------------------------------------------------
// soc_key_input_pio
//   Avalon-MM slave input PIO for push-buttons and switches. Each input bit is
//   synchronised and debounced, selected edges of the debounced value are
//   latched into an edge-capture register, and a maskable level interrupt is
//   raised while any unmasked captured bit is set. Reads are combinational
//   (zero wait states).
//
//   Register map (word offsets):
//     0 data        R   debounced inputs; writes ignored
//     1 reserved    R   reads 0; writes ignored
//     2 irqmask     RW  per-bit interrupt enable
//     3 edgecapture R/W1C captured edges; writing 1 clears a bit
//
//   Parameters:
//     WIDTH           - number of inputs (1..32)
//     DEBOUNCE_CYCLES - stable clocks required per input; 0 bypasses
//     EDGE_TYPE       - EDGE_RISING / EDGE_FALLING / EDGE_ANY
//     IDLE_LEVEL      - reset level of the synchronisers and debounced bits
//
//   Ports:
//     clk        in   system clock
//     reset_n    in   asynchronous active-low reset
//     address    in   register select
//     chipselect in   slave select
//     write_n    in   active-low write strobe
//     writedata  in   write data
//     in_port    in   asynchronous external inputs
//     readdata   out  read data, zero-extended above WIDTH
//     irq        out  level interrupt request
// -----------------------------------------------------------------------------
module soc_key_input_pio
    import soc_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = EDGE_FALLING,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    input  logic [WIDTH-1:0]     in_port,
    output logic [31:0]          readdata,
    output logic                 irq
);

    localparam bit               IDLE_BIT = (IDLE_LEVEL != 0);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_BIT}};

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edgecap_clr;
    logic             wr_en;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata are meaningful.
    assign unused_wdata = ^writedata;

    // Selected edges of the debounced value.
    function automatic logic [WIDTH-1:0] edge_detect(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] prev);
        case (EDGE_TYPE)
            EDGE_RISING:  return cur & ~prev;
            EDGE_FALLING: return ~cur & prev;
            default:      return cur ^ prev;
        endcase
    endfunction

    // ---- stage: per-bit synchroniser + debounce (in_port -> deb) ----
    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_bit
            soc_input_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .IDLE_LEVEL     (IDLE_BIT)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .in_bit (in_port[g]),
                .deb    (deb[g])
            );
        end
    endgenerate

    // ---- stage: edge detect (deb -> deb_d) ----
    // deb_d starts at the idle level, matching deb, so leaving reset never
    // looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_d <= IDLE_VEC;
        end else begin
            deb_d <= deb;
        end
    end

    assign edge_vec = edge_detect(deb, deb_d);

    // ---- stage: register file (edge_vec -> edgecapture, irqmask) ----
    assign wr_en       = pio_write_strobe(chipselect, write_n);
    assign edgecap_clr = (wr_en && (address == PIO_ADDR_EDGECAP)) ? writedata[WIDTH-1:0]
                                                                   : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // OR-ing the new edges after the clear lets a same-cycle edge win
            // over a write-1-clear, so no event is ever lost.
            edgecapture <= (edgecapture & ~edgecap_clr) | edge_vec;
        end
    end

    // ---- stage: combinational read mux and interrupt ----
    always_comb begin
        readdata = '0;
        case (pio_addr_e'(address))
            PIO_ADDR_DATA:    readdata = 32'(deb);
            PIO_ADDR_DIR:     readdata = '0;
            PIO_ADDR_IRQMASK: readdata = 32'(irqmask);
            PIO_ADDR_EDGECAP: readdata = 32'(edgecapture);
            default:          readdata = '0;
        endcase
    end

    assign irq = |(edgecapture & irqmask);

endmodule : soc_key_input_pio

// File: tb/tb_soc_key_input_pio.sv
// -----------------------------------------------------------------------------
// tb_soc_key_input_pio
//   Directed and randomised stimulus for soc_key_input_pio (WIDTH=4,
//   DEBOUNCE_CYCLES=4, falling edges, idle-high). A reference model tracks the
//   accepted input level from the history of sampled inputs: a bit changes
//   once the synchronised input has shown the opposite level for
//   DEBOUNCE_CYCLES consecutive clocks.
// -----------------------------------------------------------------------------
module tb_soc_key_input_pio;

    localparam int W  = 4;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [W-1:0] m_deb, m_deb_prev, m_ecap, m_mask;
    logic [W-1:0] samp[$];   // in_port value taken at each clock edge

    soc_key_input_pio #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC),
        .EDGE_TYPE      (1),
        .IDLE_LEVEL     (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_deb      = '1;
        m_deb_prev = '1;
        m_ecap     = '0;
        m_mask     = '0;
        samp.delete();
        // The synchronisers come out of reset holding the idle level.
        for (int j = 0; j < DC + 1; j++) samp.push_back('1);
    endtask

    // Advance the model across one clock edge using the bus/input values
    // that the design sees at that edge.
    task automatic model_step();
        logic [W-1:0] clr, nxt;
        bit           flip;
        int           n;
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
        n = samp.size();
        nxt = m_deb;
        for (int i = 0; i < W; i++) begin
            // samp[n-2] is what the second synchroniser holds before this edge.
            flip = 1'b1;
            for (int j = 2; j <= DC + 1; j++)
                if (samp[n-j][i] == m_deb[i]) flip = 1'b0;
            if (flip) nxt[i] = ~m_deb[i];
        end
        // Falling edge of the accepted level seen one clock after it changes.
        m_ecap     = (m_ecap & ~clr) | (m_deb_prev & ~m_deb);
        m_deb_prev = m_deb;
        m_deb      = nxt;
        samp.push_back(in_port);
        if (samp.size() > 12) void'(samp.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_step();
        #1;
    endtask

    function automatic logic [31:0] exp_rd(input int a);
        case (a)
            0:       return 32'(m_deb);
            2:       return 32'(m_mask);
            3:       return 32'(m_ecap);
            default: return 32'd0;
        endcase
    endfunction

    // All four registers plus irq against the model (4 ns of a 10 ns cycle).
    task automatic check_regs(input string tag);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            chk($sformatf("%s_rd%0d", tag, a), readdata, exp_rd(a));
        end
        chk({tag, "_irq"}, {31'd0, irq}, {31'd0, |(m_ecap & m_mask)});
    endtask

    // Direct read against a value fixed by the directed scenario.
    task automatic rd_const(input string tag, input int a, input logic [31:0] exp);
        address = 2'(a);
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic write_reg(input int a, input logic [31:0] d);
        address    = 2'(a);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic ticks_chk(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            tick();
            check_regs(tag);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        model_reset();

        // Reset state
        tick();
        tick();
        check_regs("reset");
        rd_const("reset_data", 0, 32'h0000_000F);
        reset_n = 1'b1;
        ticks_chk(2, "idle");
        rd_const("idle_dir", 1, 32'h0);

        // Bit 0 falls: visible at k+5, captured at k+6
        in_port = 4'hE;
        tick();                       // edge k samples the change
        check_regs("b0_k");
        ticks_chk(3, "b0_wait");      // k+1..k+3
        tick();                       // k+4
        check_regs("b0_k4");
        rd_const("b0_data_k4", 0, 32'h0000_000F);
        tick();                       // k+5
        check_regs("b0_k5");
        rd_const("b0_data_k5", 0, 32'h0000_000E);
        rd_const("b0_ecap_k5", 3, 32'h0);
        tick();                       // k+6
        check_regs("b0_k6");
        rd_const("b0_ecap_k6", 3, 32'h1);
        chk("b0_irq_masked", {31'd0, irq}, 32'd0);

        // Unmask, then clear
        write_reg(2, 32'h1);
        check_regs("mask");
        chk("mask_irq", {31'd0, irq}, 32'd1);
        write_reg(3, 32'h1);
        check_regs("clr");
        chk("clr_irq", {31'd0, irq}, 32'd0);
        rd_const("clr_ecap", 3, 32'h0);

        // Bit 2 glitch of 3 cycles is rejected
        in_port = 4'hA;
        ticks_chk(3, "glitch");
        in_port = 4'hE;
        ticks_chk(8, "glitch_after");
        rd_const("glitch_data", 0, 32'h0000_000E);
        rd_const("glitch_ecap", 3, 32'h0);

        // Bit 1 edge coincides with a write-1-clear of bit 1: set wins
        in_port = 4'hC;
        tick();                       // edge k
        ticks_chk(5, "b1_wait");      // k+1..k+5
        write_reg(3, 32'h2);          // edge k+6: set and clear together
        check_regs("b1_race");
        rd_const("b1_race_ecap", 3, 32'h2);
        write_reg(3, 32'h2);
        check_regs("b1_clr");
        rd_const("b1_clr_ecap", 3, 32'h0);

        // Reset in the middle of a debounce count
        in_port = 4'h0;
        tick();                       // edge k
        ticks_chk(3, "rst_mid");      // counters of bits 3,2 at 2
        reset_n = 1'b0;
        model_reset();
        #1;
        check_regs("in_rst");
        rd_const("in_rst_data", 0, 32'h0000_000F);
        tick();
        tick();
        reset_n = 1'b1;
        ticks_chk(5, "post_rst");     // edges r..r+4
        rd_const("post_rst_data4", 0, 32'h0000_000F);
        tick();                       // r+5
        check_regs("post_rst5");
        rd_const("post_rst_data5", 0, 32'h0);
        tick();                       // r+6
        check_regs("post_rst6");
        rd_const("post_rst_ecap", 3, 32'hF);

        // Randomised inputs and bus writes
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(3) == 0) in_port = 4'($urandom);
            address   = 2'($urandom_range(3));
            writedata = $urandom;
            if ($urandom_range(3) == 0) begin
                chipselect = 1'b1;
                write_n    = 1'b0;
            end
            tick();
            chipselect = 1'b0;
            write_n    = 1'b1;
            check_regs("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_soc_key_input_pio

// File: doc/soc_key_input_pio.md
Name: soc_key_input_pio

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the hex-digit output PIO.
- Samples asynchronous board inputs (push-buttons or switches) and synchronises and debounces them per bit.
- Latches selected edges into an edge-capture register and raises a maskable level interrupt to the Nios II.
- Sits on the system interconnect beside the existing output PIOs, with the same zero-wait-state register access.

Parameters:
- WIDTH, 4: number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000: clk cycles an input must be stable before it is accepted; 0 bypasses debounce.
- EDGE_TYPE, 1: edge detected on the debounced value; 0 rising, 1 falling, 2 any.
- IDLE_LEVEL, 1: reset value replicated into every synchroniser and debounced bit (keys are idle-high).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  read data, zero-extended
- irq  out  1  level interrupt request

Behaviour:
- Reset reset_n, asynchronous, active-low; clock clk.
- On reset:
  - sync1, sync2 and deb are set to {WIDTH{IDLE_LEVEL}}.
  - Debounce counters, irqmask and edgecapture are set to 0.
  - irq=0; readdata reflects the register state combinationally.
- Synchroniser: two-flop chain in_port→sync1→sync2, always enabled.
- Debounce, per bit i, with a counter of width clog2(DEBOUNCE_CYCLES+1):
  - sync2[i]==deb[i]: counter cleared.
  - Otherwise the counter increments each cycle.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 (and still sync2[i]!=deb[i]): deb[i]<=sync2[i] and the counter clears.
  - Any sync2 glitch back to deb before that edge restarts the count.
  - DEBOUNCE_CYCLES=0: deb<=sync2 every cycle.
- Latency: a change of in_port sampled at edge k is visible in deb, and at address 0, after edge k+1+DEBOUNCE_CYCLES (k+2 when bypassed).
- Edge detect: deb_d is deb delayed 1 cycle. The edge vector is:
  - EDGE_TYPE 0: deb&~deb_d
  - EDGE_TYPE 1: ~deb&deb_d
  - EDGE_TYPE 2: deb^deb_d
  - deb_d resets to IDLE_LEVEL, so reset produces no spurious edge.
- edgecapture[i] sets on the edge after edge[i] is asserted and stays set until cleared.
- Register map (write = chipselect & ~write_n, acts on the rising edge; read is combinational, zero wait):
  - addr 0 data: read deb; writes ignored.
  - addr 1 reserved: reads 0; writes ignored.
  - addr 2 irqmask: read/write writedata[WIDTH-1:0].
  - addr 3 edgecapture: read captured bits; a write of 1 clears that bit, 0 leaves it unchanged.
- Simultaneous edge set and write-1-clear on the same bit in the same cycle: set wins, bit remains 1.
- irq = |(edgecapture & irqmask), combinational from registers. It deasserts the cycle after the clearing write or the mask write.
- readdata[31:WIDTH] is always 0. Reads have no side effects.
- Reset mid-debounce abandons the count; deb returns to IDLE_LEVEL.

Decomposition:
- Shared package soc_pio_pkg:
  - Address constants PIO_ADDR_DATA=0, PIO_ADDR_DIR=1, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGECAP=3.
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings.
  - Reused by the existing output PIOs.
- One sub-module: soc_input_debounce, a single bit containing the synchroniser, counter and stable output. It is instantiated WIDTH times in a generate loop. Parameters DEBOUNCE_CYCLES and IDLE_LEVEL.
- Edge logic, registers and read mux live in the top module.

Test Plan (bench uses WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, IDLE_LEVEL=1):
- Reset, then read addrs 0-3 → 0x0000000F, 0, 0, 0; irq=0.
- in_port 4'hF→4'hE held, change sampled at edge k → addr 0 reads 0xE after edge k+5; edgecapture reads 0x1 after edge k+6; irq still 0 with mask 0.
- Write irqmask=0x1, then edgecapture=0x1 pending → irq=1 the cycle after the mask write; write addr 3 0x1 → irq=0 next cycle, edgecapture=0.
- Bit 2 pulses low for 3 cycles and returns high → deb never changes, edgecapture stays 0, irq stays 0.
- Bit 1 falling edge lands in the same cycle as a write of 0x2 to addr 3 → edgecapture[1]=1 afterwards; a second 0x2 write clears it.
- Assert reset_n low mid-debounce (counter=2) with in_port=4'h0 then release and hold 4'h0 → deb=0xF after reset; after release and stability deb becomes 0x0, edgecapture=0xF.
